// File: rtl/moxie_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the Moxie core.
// Master 0 is instruction fetch and master 1 is data. Arbitration is round-robin and registered.
// Each grant is held for the whole bus cycle of the winning master.
// A watchdog aborts a strobe that the slave never acknowledges.
module moxie_wb_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    // master 0 (instruction)
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1 (data)
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // shared slave
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    // current grant {m1, m0}
    output logic [1:0]      gnt_o
);

    // The stalled cycle that sees this count value is the TIMEOUT-th one, so it triggers the abort.
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1,
        StAbort
    } state_e;

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // last_gnt_q is loaded on grant entry, so it names the owner while granted or aborting.
    logic cur_cyc;
    logic cur_stb;
    assign cur_cyc = last_gnt_q ? m1_cyc_i : m0_cyc_i;
    assign cur_stb = last_gnt_q ? m1_stb_i : m0_stb_i;

    // State, round-robin pointer and watchdog counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Next-state: arbitration in idle, tenure tracking and watchdog while granted.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        unique case (state_q)
            StIdle: begin
                tmo_cnt_d = '0;
                // On contention m0 wins only if m1 had the previous tenure.
                if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                    state_d    = StGnt0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = StGnt1;
                    last_gnt_d = 1'b1;
                end
            end
            StGnt0, StGnt1: begin
                if (!cur_cyc) begin
                    state_d   = StIdle;
                    tmo_cnt_d = '0;
                end else if (s_ack_i || !cur_stb) begin
                    // An ack on the would-be timeout cycle still wins.
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d   = StAbort;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            StAbort: begin
                state_d   = StIdle;
                tmo_cnt_d = '0;
            end
            default: begin
                state_d   = StIdle;
                tmo_cnt_d = '0;
            end
        endcase
    end

    // Bus steering: route the owner to the slave and the slave response back to the masters.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        unique case (state_q)
            StGnt0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                gnt_o    = 2'b01;
            end
            StGnt1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                gnt_o    = 2'b10;
            end
            StAbort: begin
                m0_err_o = ~last_gnt_q;
                m1_err_o = last_gnt_q;
            end
            StIdle: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Self-checking bench for moxie_wb_arbiter.
// Directed vector table, hand-written timeout/reset sequences, then random traffic against a reference model.
module tb_moxie_wb_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned TW      = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr  [2];
    logic [DW-1:0] m_wdat [2];
    logic [SW-1:0] m_sel  [2];
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic [1:0]    ack_w, err_w;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack;
    logic [1:0]    gnt;

    moxie_wb_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .m0_cyc_i (m_cyc[0]),
        .m0_stb_i (m_stb[0]),
        .m0_we_i  (m_we[0]),
        .m0_adr_i (m_adr[0]),
        .m0_dat_i (m_wdat[0]),
        .m0_sel_i (m_sel[0]),
        .m0_dat_o (m0_rdat),
        .m0_ack_o (ack_w[0]),
        .m0_err_o (err_w[0]),
        .m1_cyc_i (m_cyc[1]),
        .m1_stb_i (m_stb[1]),
        .m1_we_i  (m_we[1]),
        .m1_adr_i (m_adr[1]),
        .m1_dat_i (m_wdat[1]),
        .m1_sel_i (m_sel[1]),
        .m1_dat_o (m1_rdat),
        .m1_ack_o (ack_w[1]),
        .m1_err_o (err_w[1]),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_sel_o  (s_sel),
        .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, who is being told about a timeout, how long the owner
    // has been stalled, and who had the previous tenure.
    int         mdl_owner;
    int         mdl_abort;
    int         mdl_wait;
    int         mdl_prev;
    logic [1:0] exp_ack, exp_err;

    typedef struct packed {
        logic       c0, s0, c1, s1, ack;
        logic [1:0] gnt;
        logic       scyc, a0, a1, e0, e1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_abort = -1;
        mdl_wait  = 0;
        mdl_prev  = 1;
        exp_ack   = '0;
        exp_err   = '0;
    endtask

    task automatic check_model();
        logic [1:0] eg, ea, ee;
        logic       esc, estb;
        eg = '0; ea = '0; ee = '0; esc = 1'b0; estb = 1'b0;
        if (mdl_owner >= 0) begin
            eg[mdl_owner] = 1'b1;
            esc           = m_cyc[mdl_owner];
            estb          = m_stb[mdl_owner];
            ea[mdl_owner] = s_ack & m_stb[mdl_owner];
        end
        if (mdl_abort >= 0) ee[mdl_abort] = 1'b1;
        chk("mdl_gnt", gnt, eg);
        chk("mdl_s_cyc", s_cyc, esc);
        chk("mdl_s_stb", s_stb, estb);
        chk("mdl_ack", ack_w, ea);
        chk("mdl_err", err_w, ee);
        if (mdl_owner >= 0) begin
            chk("mdl_s_adr", s_adr, m_adr[mdl_owner]);
            chk("mdl_s_dat", s_wdat, m_wdat[mdl_owner]);
            chk("mdl_s_sel", s_sel, m_sel[mdl_owner]);
            chk("mdl_s_we", s_we, m_we[mdl_owner]);
            chk("mdl_m0_dat", m0_rdat, s_rdat);
            chk("mdl_m1_dat", m1_rdat, s_rdat);
        end
        exp_ack = ea;
        exp_err = ee;
    endtask

    // Clock-edge update of the model from the inputs held across the edge.
    task automatic model_step();
        int w;
        w = -1;
        if (mdl_abort >= 0) begin
            mdl_abort = -1;
        end else if (mdl_owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) w = 1 - mdl_prev;
            else if (m_cyc[0]) w = 0;
            else if (m_cyc[1]) w = 1;
            if (w >= 0) begin
                mdl_owner = w;
                mdl_prev  = w;
                mdl_wait  = 0;
            end
        end else if (!m_cyc[mdl_owner]) begin
            mdl_owner = -1;
        end else if (s_ack || !m_stb[mdl_owner]) begin
            mdl_wait = 0;
        end else begin
            mdl_wait++;
            if (mdl_wait >= int'(TIMEOUT)) begin
                mdl_abort = mdl_owner;
                mdl_owner = -1;
                mdl_wait  = 0;
            end
        end
    endtask

    // Inputs are driven 1 after the edge; settle() samples mid-cycle, advance() crosses an edge.
    task automatic settle();
        #4;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(input logic c0, s0, c1, s1, ack, input logic [1:0] g,
                                input logic sc, a0, a1, e0, e1);
        vec_t v;
        v = '{c0: c0, s0: s0, c1: c1, s1: s1, ack: ack, gnt: g,
              scyc: sc, a0: a0, a1: a1, e0: e0, e1: e1};
        return v;
    endfunction

    task automatic new_req(input int i);
        m_adr[i]  = $urandom();
        m_wdat[i] = $urandom();
        m_sel[i]  = SW'($urandom());
        m_we[i]   = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_master(input int i);
        if (!m_cyc[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
                new_req(i);
            end
        end else if (exp_err[i]) begin
            if ($urandom_range(0, 3) != 0) begin
                m_cyc[i] = 1'b0;
                m_stb[i] = 1'b0;
            end
        end else if (exp_ack[i]) begin
            if ($urandom_range(0, 2) == 0) begin
                m_stb[i] = 1'($urandom_range(0, 1));
                new_req(i);
            end else begin
                m_cyc[i] = 1'b0;
                m_stb[i] = 1'b0;
            end
        end else if (!m_stb[i]) begin
            m_stb[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 15) == 0) begin
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
        end
    endtask

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_wdat[i] = '0; m_sel[i] = '0;
        end
        s_ack  = 1'b0;
        s_rdat = 32'hDEAD_BEEF;
        model_reset();

        // Directed vectors: {c0 s0 c1 s1 ack} -> {gnt s_cyc ack0 ack1 err0 err1}
        // Single m1 read, slave acks on the third granted cycle.
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
        // Fairness: both request, grants alternate with one idle cycle between tenures.
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        // Locked cycle: m1 keeps cyc across 3 strobes while m0 waits.
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));

        // Reset state
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_ack", ack_w, 2'b00);
        chk("rst_err", err_w, 2'b00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        m_adr[1] = 32'h0000_1000;
        m_adr[0] = 32'h0000_0400;
        foreach (vecs[i]) begin
            m_cyc = {vecs[i].c1, vecs[i].c0};
            m_stb = {vecs[i].s1, vecs[i].s0};
            s_ack = vecs[i].ack;
            settle();
            chk($sformatf("tbl%0d_gnt", i), gnt, vecs[i].gnt);
            chk($sformatf("tbl%0d_s_cyc", i), s_cyc, vecs[i].scyc);
            chk($sformatf("tbl%0d_ack", i), ack_w, {vecs[i].a1, vecs[i].a0});
            chk($sformatf("tbl%0d_err", i), err_w, {vecs[i].e1, vecs[i].e0});
            if (vecs[i].a1) chk($sformatf("tbl%0d_m1_dat", i), m1_rdat, 32'hDEAD_BEEF);
            advance();
        end

        // Timeout: m0 is never acked; abort after TIMEOUT stalled cycles.
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
        settle(); chk("to_idle_gnt", gnt, 2'b00); advance();
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            settle();
            chk("to_stall_gnt", gnt, 2'b01);
            chk("to_stall_err", err_w, 2'b00);
            advance();
        end
        settle();
        chk("to_abort_err", err_w, 2'b01);
        chk("to_abort_s_cyc", s_cyc, 1'b0);
        chk("to_abort_gnt", gnt, 2'b00);
        advance();
        // m0 keeps cyc high: idle, then a fresh grant.
        settle(); chk("to_post_gnt", gnt, 2'b00); chk("to_post_err", err_w, 2'b00); advance();
        // Ack exactly on the TIMEOUT-th stalled cycle wins.
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) begin
            settle(); chk("bd_stall_gnt", gnt, 2'b01); advance();
        end
        s_ack = 1'b1;
        settle(); chk("bd_ack", ack_w, 2'b01); chk("bd_err", err_w, 2'b00); advance();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        settle(); chk("bd_hold_gnt", gnt, 2'b01); chk("bd_hold_err", err_w, 2'b00); advance();
        settle(); chk("bd_idle_gnt", gnt, 2'b00); advance();

        // Reset in the middle of a granted, strobing transfer.
        m_cyc = 2'b01; m_stb = 2'b01;
        settle(); advance();
        settle(); chk("mr_pre_gnt", gnt, 2'b01);
        s_ack = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mr_gnt", gnt, 2'b00);
        chk("mr_s_cyc", s_cyc, 1'b0);
        chk("mr_s_stb", s_stb, 1'b0);
        chk("mr_ack", ack_w, 2'b00);
        chk("mr_err", err_w, 2'b00);
        chk("mr_m0_dat", m0_rdat, '0);
        model_reset();
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        settle(); chk("mr_post_gnt", gnt, 2'b00); advance();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) drive_master(i);
            s_ack  = ($urandom_range(0, 2) == 0);
            s_rdat = $urandom();
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
